mips_multicycle_ctrl: RTL and testbench

Multicycle control unit for the Soc_Mips core. A Moore state machine sequences the shared ALU, register file, instruction/data memory port and PC through fetch, decode, execute, memory and writeback. It also detects and reports exceptions on the existing 3-bit ExceptionCause output. It sits between the instruction register fields and the datapath muxes and write enables.

---
 rtl/mips_multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control unit for the Soc_Mips core.
//
// A Moore state machine sequences the shared ALU, register file, memory port and PC through
// fetch, decode, execute, memory and writeback. It also detects illegal opcodes, signed overflow
// on add/sub/addi, and misaligned lw/sw addresses, and records the cause.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   Opcode, Funct     IR fields [31:26] and [5:0]
//   Zero, Overflow    ALU flags (combinational from the current ALU operation)
//   AddrLo            ALUResult[1:0], the computed memory address
//   MemReady          memory port completes the current access this cycle
//   PCWrite .. CauseWrite, ALUSrcB, ALUOp, PCSource   datapath strobes and selects
//   ExceptionCause    registered cause of the most recent exception
//   State             current state encoding, for debug
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       Overflow,
    input  logic [1:0] AddrLo,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       EPCWrite,
    output logic       CauseWrite,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [2:0] ExceptionCause,
    output logic [3:0] State
);

    localparam logic [2:0] EXC_ILLEGAL = 3'b001;
    localparam logic [2:0] EXC_OVF     = 3'b010;
    localparam logic [2:0] EXC_ALIGN   = 3'b011;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd   = 6'b100000;
    localparam logic [5:0] FnSub   = 6'b100010;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11,
        StExc    = 4'd12
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cause_q, cause_d;

    // Zero only qualifies PCWriteCond inside the datapath; the controller never looks at it.
    logic unused_zero;
    assign unused_zero = Zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            cause_q <= 3'b000;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next state. The cause register only loads on a transition into EXC.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            StFetch:  if (MemReady) state_d = StDecode;
            StDecode: begin
                case (Opcode)
                    OpRtype:    state_d = StExec;
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default: begin
                        state_d = StExc;
                        cause_d = EXC_ILLEGAL;
                    end
                endcase
            end
            StMemAdr: begin
                if (AddrLo != 2'b00) begin
                    state_d = StExc;
                    cause_d = EXC_ALIGN;
                end else if (Opcode == OpLw) begin
                    state_d = StMemRd;
                end else begin
                    state_d = StMemWr;
                end
            end
            StMemRd:  if (MemReady) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (MemReady) state_d = StFetch;
            StExec: begin
                // Only the trapping forms trap; addu/subu ignore Overflow.
                if (Overflow && (Funct == FnAdd || Funct == FnSub)) begin
                    state_d = StExc;
                    cause_d = EXC_OVF;
                end else begin
                    state_d = StAluWb;
                end
            end
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StAddiEx: begin
                if (Overflow) begin
                    state_d = StExc;
                    cause_d = EXC_OVF;
                end else begin
                    state_d = StAddiWb;
                end
            end
            StAddiWb: state_d = StFetch;
            StJump:   state_d = StFetch;
            StExc:    state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        EPCWrite    = 1'b0;
        CauseWrite  = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            StDecode: ALUSrcB = 2'b11;
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            StExec: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            StBranch: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCSource    = 2'b01;
                PCWriteCond = 1'b1;
            end
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StAddiWb: RegWrite = 1'b1;
            StJump: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            StExc: begin
                EPCWrite   = 1'b1;
                CauseWrite = 1'b1;
                PCWrite    = 1'b1;
                PCSource   = 2'b11;
            end
            default: ;
        endcase
        // Reset aborts any in-flight instruction: no architectural write may escape.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            EPCWrite    = 1'b0;
            CauseWrite  = 1'b0;
        end
    end

    assign State          = state_q;
    assign ExceptionCause = cause_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with hand-computed expected values.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode, Funct;
    logic       Zero, Overflow, MemReady;
    logic [1:0] AddrLo;
    logic       PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, IorD, RegWrite;
    logic       RegDst, MemtoReg, ALUSrcA, EPCWrite, CauseWrite;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [2:0] ExceptionCause;
    logic [3:0] State;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .Overflow(Overflow), .AddrLo(AddrLo), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .EPCWrite(EPCWrite),
        .CauseWrite(CauseWrite), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .ExceptionCause(ExceptionCause), .State(State)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 2ns after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Step one cycle and confirm the new state.
    task automatic step(input string tag, input logic [3:0] exp_state);
        tick();
        check(tag, State, exp_state);
    endtask

    initial begin
        rst = 1'b1; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0; Overflow = 1'b0;
        AddrLo = 2'b00; MemReady = 1'b1;

        // Reset state; IRWrite/PCWrite would assert in FETCH but reset suppresses them.
        tick(); tick();
        #1;
        check("rst_state", State, 4'd0);
        check("rst_cause", ExceptionCause, 3'b000);
        check("rst_irwrite", IRWrite, 1'b0);
        check("rst_pcwrite", PCWrite, 1'b0);
        rst = 1'b0;
        #1;
        check("fetch_irwrite", IRWrite, 1'b1);
        check("fetch_memread", MemRead, 1'b1);
        check("fetch_alusrcb", ALUSrcB, 2'b01);

        // R-type add, no overflow: 0,1,6,7,0
        Opcode = 6'b000000; Funct = 6'b100000; Overflow = 1'b0;
        step("add_decode", 4'd1);
        check("decode_alusrcb", ALUSrcB, 2'b11);
        check("decode_regwrite", RegWrite, 1'b0);
        step("add_exec", 4'd6);
        check("exec_aluop", ALUOp, 2'b10);
        check("exec_alusrca", ALUSrcA, 1'b1);
        check("exec_regwrite", RegWrite, 1'b0);
        step("add_aluwb", 4'd7);
        check("aluwb_regwrite", RegWrite, 1'b1);
        check("aluwb_regdst", RegDst, 1'b1);
        check("aluwb_memtoreg", MemtoReg, 1'b0);
        step("add_done", 4'd0);

        // lw with two MemReady-low cycles in MEMRD: 0,1,2,3,3,3,4,0
        Opcode = 6'b100011; AddrLo = 2'b00;
        step("lw_decode", 4'd1);
        step("lw_memadr", 4'd2);
        check("memadr_alusrcb", ALUSrcB, 2'b10);
        MemReady = 1'b0;
        step("lw_memrd0", 4'd3);
        check("memrd_iord", IorD, 1'b1);
        check("memrd_memread", MemRead, 1'b1);
        step("lw_memrd1", 4'd3);
        step("lw_memrd2", 4'd3);
        check("memrd_hold_iord", IorD, 1'b1);
        MemReady = 1'b1;
        step("lw_memwb", 4'd4);
        check("memwb_memtoreg", MemtoReg, 1'b1);
        check("memwb_regwrite", RegWrite, 1'b1);
        check("memwb_regdst", RegDst, 1'b0);
        step("lw_done", 4'd0);

        // sw misaligned: 0,1,2,12,0
        Opcode = 6'b101011; AddrLo = 2'b10;
        step("sw_decode", 4'd1);
        step("sw_memadr", 4'd2);
        check("sw_memwrite_adr", MemWrite, 1'b0);
        step("sw_exc", 4'd12);
        check("align_cause", ExceptionCause, 3'b011);
        check("exc_pcsource", PCSource, 2'b11);
        check("exc_epcwrite", EPCWrite, 1'b1);
        check("exc_causewrite", CauseWrite, 1'b1);
        check("exc_pcwrite", PCWrite, 1'b1);
        check("exc_memwrite", MemWrite, 1'b0);
        step("sw_done", 4'd0);
        AddrLo = 2'b00;

        // addi overflow trap, then addu with Overflow=1 completes and cause stays 010
        Opcode = 6'b001000; Overflow = 1'b1;
        step("addi_decode", 4'd1);
        step("addi_ex", 4'd9);
        check("addiex_regwrite", RegWrite, 1'b0);
        step("addi_exc", 4'd12);
        check("ovf_cause", ExceptionCause, 3'b010);
        check("ovf_regwrite", RegWrite, 1'b0);
        step("addi_done", 4'd0);
        Opcode = 6'b000000; Funct = 6'b100001;
        step("addu_decode", 4'd1);
        step("addu_exec", 4'd6);
        step("addu_aluwb", 4'd7);
        check("addu_regwrite", RegWrite, 1'b1);
        check("addu_cause_hold", ExceptionCause, 3'b010);
        step("addu_done", 4'd0);

        // sub with overflow traps in EXEC
        Funct = 6'b100010;
        step("sub_decode", 4'd1);
        step("sub_exec", 4'd6);
        step("sub_exc", 4'd12);
        step("sub_done", 4'd0);
        Overflow = 1'b0;

        // Illegal opcode: 0,1,12,0
        Opcode = 6'b111111;
        step("ill_decode", 4'd1);
        step("ill_exc", 4'd12);
        check("ill_cause", ExceptionCause, 3'b001);
        step("ill_done", 4'd0);

        // beq with Zero=1: 0,1,8,0
        Opcode = 6'b000100; Zero = 1'b1;
        step("beq_decode", 4'd1);
        step("beq_branch", 4'd8);
        check("beq_pcwritecond", PCWriteCond, 1'b1);
        check("beq_pcsource", PCSource, 2'b01);
        check("beq_aluop", ALUOp, 2'b01);
        check("beq_pcwrite", PCWrite, 1'b0);
        step("beq_done", 4'd0);
        Zero = 1'b0;

        // j: 0,1,11,0
        Opcode = 6'b000010;
        step("j_decode", 4'd1);
        step("j_jump", 4'd11);
        check("j_pcwrite", PCWrite, 1'b1);
        check("j_pcsource", PCSource, 2'b10);
        step("j_done", 4'd0);

        // Reset mid-lw while in MEMRD; cause (001) is cleared by reset
        Opcode = 6'b100011;
        step("rlw_decode", 4'd1);
        step("rlw_memadr", 4'd2);
        MemReady = 1'b0;
        step("rlw_memrd", 4'd3);
        rst = 1'b1;
        #1;
        check("rlw_rst_regwrite", RegWrite, 1'b0);
        MemReady = 1'b1;
        step("rlw_rst_state", 4'd0);
        check("rlw_rst_cause", ExceptionCause, 3'b000);
        check("rlw_rst_irwrite", IRWrite, 1'b0);
        rst = 1'b0; MemReady = 1'b0;
        #1;
        check("fetchwait_irwrite", IRWrite, 1'b0);
        step("fetchwait0", 4'd0);
        step("fetchwait1", 4'd0);
        check("fetchwait_memread", MemRead, 1'b1);
        MemReady = 1'b1;
        #1;
        check("fetchready_irwrite", IRWrite, 1'b1);
        step("fetch_go", 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
